// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS core's data-memory interface.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int unsigned DM_ADDR_W   = 10;
    localparam int unsigned DM_WAIT_DEF = 2;
    localparam int unsigned DM_CNT_W    = 4;
    localparam logic [3:0]  BE_ALL      = 4'hf;

    // Replace the byte lanes of old_word selected by be with the lanes of new_word.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-addressed storage with byte-lane writes and a registered read/readback port.
module dm_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] merged;

    assign merged = be_merge(mem[addr], wdata, be);

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merged;
    end

    // Read register: clr wins, a store returns its merged word, a load returns the stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (we) begin
            rdata <= merged;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: req/ready intake, WAIT-cycle countdown, one rvalid pulse per request.
module dm_resp
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned WAIT   = DM_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W+1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int unsigned AW = ADDR_W + 2;
    localparam logic [DM_CNT_W-1:0] CNT_LOAD = (WAIT == 0) ? '0 : DM_CNT_W'(WAIT - 1);

    dm_state_t           state, state_nxt;
    logic [DM_CNT_W-1:0] cnt, cnt_nxt;
    logic                accept, access;

    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [3:0]    lat_be;
    logic [31:0]   lat_wdata;

    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic          misal;
    logic          arr_we, arr_re, arr_clr;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_LOAD;
                    if (WAIT == 0) begin
                        state_nxt = RESP;
                        access    = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    access    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With WAIT=0 the access edge is the acceptance edge, so use the live payload.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_be    = lat_be;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_be    = be;
            acc_wdata = wdata;
        end
        misal   = (acc_addr[1:0] != 2'b00);
        arr_we  = access & ~rst & acc_we & ~misal;
        arr_re  = access & ~rst & ~acc_we & ~misal;
        arr_clr = access & ~rst & misal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ready  <= (state_nxt == IDLE);
            rvalid <= (state_nxt == RESP);
            if (access) err <= misal;
            if (accept) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_be    <= be;
                lat_wdata <= wdata;
            end
        end
    end

    dm_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .clr   (arr_clr),
        .addr  (acc_addr[AW-1:2]),
        .be    (acc_be),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

endmodule
